keypad_entry_display: RTL and testbench

Parametrised keypad-to-display subsystem that succeeds the fixed 4x4, two-digit keypad/display top.
- Scans an ROWS x COLS matrix keypad and debounces it by counting.
- Accepts one key per press and shifts the key's hex value into an NUM_DIGITS-deep entry buffer.
- Time-multiplexes the buffer onto a common-segment 7-segment display.
- Sits directly under the board top, driven by the HSOSC-derived clk.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_scan_fsm.sv | 141 ++++++++++++++
 rtl/keypad_entry_display.sv | 103 ++++++++++
 tb/tb_keypad_entry_display.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry/display subsystem.
// Contents: scanner state enum, key map (row*4+col -> hex value),
// active-low 7-segment decoder and the blank segment pattern.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Physical layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Segments {g,f,e,d,c,b,a}, a lit segment is 0.
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/keypad_scan_fsm.sv
// Matrix keypad scanner with counting debounce.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   keypad_cols [COLS]  column sense, active-low, asynchronous
//   keypad_rows [ROWS]  row drive, active-low one-hot (all ones in reset)
//   key_strobe          one-cycle pulse per accepted key
//   key_value [4]       hex value of the last accepted key
module keypad_scan_fsm
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [COLS-1:0] keypad_cols,
    output logic [ROWS-1:0] keypad_rows,
    output logic            key_strobe,
    output logic [3:0]      key_value
);
    localparam int SW = $clog2(SCAN_DIV) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]    ROW_LAST  = 2'(ROWS - 1);

    logic [COLS-1:0] cols_p0, cols_p1;
    scan_state_t     state, state_d;
    logic [1:0]      row, row_d, col, col_d, first_low;
    logic [SW-1:0]   scan_cnt, scan_cnt_d;
    logic [DW-1:0]   deb_cnt, deb_cnt_d;
    logic            strobe_d, key_low, any_low;
    logic [3:0]      value_d, col_vec, row_drive;

    // Stage p0/p1: two-flop synchroniser on the asynchronous columns
    always_ff @(posedge clk) begin
        cols_p0 <= keypad_cols;
        cols_p1 <= cols_p0;
    end

    function automatic logic [1:0] next_row(input logic [1:0] r);
        return (r == ROW_LAST) ? 2'd0 : r + 2'd1;
    endfunction

    always_comb begin
        // Columns absent from a narrower keypad read as released.
        col_vec = '1;
        col_vec[COLS-1:0] = cols_p1;
        any_low = ~&col_vec;
        first_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_vec[i]) first_low = 2'(i);
        end
        key_low = ~col_vec[col];
    end

    always_comb begin
        state_d    = state;
        row_d      = row;
        col_d      = col;
        scan_cnt_d = scan_cnt;
        deb_cnt_d  = deb_cnt;
        strobe_d   = 1'b0;
        value_d    = key_value;
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (any_low) begin
                        state_d   = DEBOUNCE;
                        col_d     = first_low;
                        deb_cnt_d = '0;
                    end else begin
                        row_d = next_row(row);
                    end
                end else begin
                    scan_cnt_d = scan_cnt + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (!key_low) begin
                    state_d    = SCAN;
                    row_d      = next_row(row);
                    scan_cnt_d = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_d  = HELD;
                    strobe_d = 1'b1;
                    value_d  = KEYMAP[{row, col}];
                end else begin
                    deb_cnt_d = deb_cnt + DW'(1);
                end
            end
            HELD: begin
                if (!key_low) begin
                    state_d   = RELEASE;
                    deb_cnt_d = '0;
                end
            end
            RELEASE: begin
                if (key_low) begin
                    state_d = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_d    = SCAN;
                    row_d      = next_row(row);
                    scan_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt + DW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
        // Row output is registered from the next row so it always matches row.
        row_drive = '1;
        row_drive[row_d] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SCAN;
            row         <= 2'd0;
            col         <= 2'd0;
            scan_cnt    <= '0;
            deb_cnt     <= '0;
            key_strobe  <= 1'b0;
            key_value   <= 4'h0;
            keypad_rows <= '1;
        end else begin
            state       <= state_d;
            row         <= row_d;
            col         <= col_d;
            scan_cnt    <= scan_cnt_d;
            deb_cnt     <= deb_cnt_d;
            key_strobe  <= strobe_d;
            key_value   <= value_d;
            keypad_rows <= row_drive[ROWS-1:0];
        end
    end

endmodule

// File: rtl/keypad_entry_display.sv
// Keypad entry buffer with multiplexed 7-segment display.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   clear                 empties the entry buffer (wins over a new key)
//   keypad_rows [ROWS]    row drive, active-low one-hot
//   keypad_cols [COLS]    column sense, active-low, asynchronous
//   key_strobe, key_value accepted-key pulse and its hex value
//   seg [7]               segments {g..a}, active-low
//   select [NUM_DIGITS]   digit enables, active-low one-hot
module keypad_entry_display
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int NUM_DIGITS      = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REFRESH_DIV     = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    output logic [ROWS-1:0]       keypad_rows,
    input  logic [COLS-1:0]       keypad_cols,
    output logic                  key_strobe,
    output logic [3:0]            key_value,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] select
);
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW     = $clog2(REFRESH_DIV) + 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [RW-1:0]     REF_LAST  = RW'(REFRESH_DIV - 1);

    logic [3:0]            digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] valid;
    logic [SLOT_W-1:0]     slot, slot_nxt;
    logic [RW-1:0]         ref_cnt;
    logic                  gap;
    logic [6:0]            slot_seg;

    keypad_scan_fsm #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_scan (
        .clk         (clk),
        .reset       (reset),
        .keypad_cols (keypad_cols),
        .keypad_rows (keypad_rows),
        .key_strobe  (key_strobe),
        .key_value   (key_value)
    );

    // Entry buffer: new key enters at digit 0, oldest falls off the top.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= '0;
        end else if (key_strobe) begin
            valid <= (valid << 1) | NUM_DIGITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (key_strobe && !clear) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                digit[i] <= digit[i-1];
            end
            digit[0] <= key_value;
        end
    end

    assign slot_nxt = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);

    // Each slot is lit for REFRESH_DIV cycles followed by one blank (gap)
    // cycle; the digit's pattern is captured during the gap so buffer
    // changes only appear at a slot boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot     <= '0;
            ref_cnt  <= '0;
            gap      <= 1'b0;
            slot_seg <= SEG_BLANK;
            seg      <= SEG_BLANK;
            select   <= '1;
        end else begin
            if (gap) begin
                gap      <= 1'b0;
                ref_cnt  <= '0;
                slot     <= slot_nxt;
                slot_seg <= valid[slot_nxt] ? hex7seg(digit[slot_nxt]) : SEG_BLANK;
            end else if (ref_cnt == REF_LAST) begin
                gap <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
            select <= gap ? '1 : ~(NUM_DIGITS'(1) << slot);
            seg    <= gap ? SEG_BLANK : slot_seg;
        end
    end

endmodule

// File: tb/tb_keypad_entry_display.sv
// Testbench for keypad_entry_display: keypad matrix model, strobe
// scoreboard, table of key presses and hand-written corner sequences.
module tb_keypad_entry_display;
    localparam int ROWS = 4, COLS = 4, ND = 4, SD = 4, DEB = 8, RD = 4;

    logic       clk = 1'b0;
    logic       reset, clear;
    logic [3:0] keypad_rows, keypad_cols, key_value, select;
    logic       key_strobe;
    logic [6:0] seg;

    keypad_entry_display #(
        .ROWS(ROWS), .COLS(COLS), .NUM_DIGITS(ND), .SCAN_DIV(SD),
        .DEBOUNCE_CYCLES(DEB), .REFRESH_DIV(RD)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .keypad_rows(keypad_rows), .keypad_cols(keypad_cols),
        .key_strobe(key_strobe), .key_value(key_value),
        .seg(seg), .select(select)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, strobes = 0, last_strobe_cyc = 0;
    always @(posedge clk) cyc++;

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    logic [15:0] press = '0;
    bit          rnd_mode = 1'b0;
    logic [3:0]  rnd_cols = '1;
    always_comb begin
        keypad_cols = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !keypad_rows[r]) keypad_cols[c] = 1'b0;
        if (rnd_mode) keypad_cols = rnd_cols;
    end

    // Scoreboard of expected key values, popped on every strobe.
    logic [3:0] exp_q [$];
    logic [3:0] exp_v;
    always @(negedge clk) begin
        if (key_strobe) begin
            strobes++;
            last_strobe_cyc = cyc;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: key_value=%h, no key expected", key_value);
            end else begin
                exp_v = exp_q.pop_front();
                if (key_value !== exp_v) begin
                    fails++;
                    $display("FAIL strobe_value: got %h expected %h", key_value, exp_v);
                end
            end
        end
    end

    // Reference model of the entry buffer.
    logic [3:0] m_digit [4];
    logic [3:0] m_valid = '0;
    logic [6:0] seg_lut [16];

    function automatic logic [6:0] exp_seg(input int k);
        return m_valid[k] ? seg_lut[m_digit[k]] : 7'h7F;
    endfunction

    task automatic model_push(input logic [3:0] v);
        for (int i = 3; i > 0; i--) m_digit[i] = m_digit[i-1];
        m_digit[0] = v;
        m_valid = {m_valid[2:0], 1'b1};
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int sel_index(input logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            4'b1111: return -1;
            default: return -2;
        endcase
    endfunction

    // Watch three refresh periods: segment content per lit digit, lit run
    // length, single blank cycle between slots, and slot order.
    task automatic check_display(input string tag);
        int idx, prev, run, prev_lit;
        bit started;
        prev = -3; run = 0; prev_lit = -1; started = 0;
        for (int n = 0; n < 3 * ND * (RD + 1); n++) begin
            @(negedge clk);
            idx = sel_index(select);
            if (idx == -2) begin
                tests++; fails++;
                $display("FAIL %s_select_onehot: got %b expected one-hot-low or all ones", tag, select);
            end
            if (idx >= 0) check($sformatf("%s_seg%0d", tag, idx), 32'(seg), 32'(exp_seg(idx)));
            if (prev == -3) begin
                prev = idx; run = 1;
            end else if (idx != prev) begin
                if (started) begin
                    if (prev == -1) check($sformatf("%s_blank_len", tag), run, 1);
                    else if (prev >= 0) check($sformatf("%s_lit_len", tag), run, RD);
                end
                if (idx >= 0 && prev_lit >= 0)
                    check($sformatf("%s_slot_order", tag), idx, (prev_lit + 1) % 4);
                if (idx >= 0) prev_lit = idx;
                started = 1;
                prev = idx; run = 1;
            end else begin
                run++;
            end
        end
    endtask

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  val;
        int          hold;
        bit          chk;
    } vec_t;
    vec_t vecs [13];

    int rel_cyc, s0;
    bit found;

    initial begin
        seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0]  = '{16'h0040, 4'h6, 100, 1'b1};
        vecs[1]  = '{16'h0001, 4'h1, 40, 1'b0};
        vecs[2]  = '{16'h0002, 4'h2, 40, 1'b0};
        vecs[3]  = '{16'h0004, 4'h3, 40, 1'b0};
        vecs[4]  = '{16'h0008, 4'hA, 40, 1'b0};
        vecs[5]  = '{16'h2000, 4'h0, 40, 1'b1};
        vecs[6]  = '{16'h0100, 4'h7, 40, 1'b0};
        vecs[7]  = '{16'h0A00, 4'h8, 40, 1'b0};
        vecs[8]  = '{16'h0800, 4'hC, 40, 1'b0};
        vecs[9]  = '{16'h0080, 4'hB, 40, 1'b0};
        vecs[10] = '{16'h1000, 4'hE, 40, 1'b0};
        vecs[11] = '{16'h4000, 4'hF, 40, 1'b0};
        vecs[12] = '{16'h8000, 4'hD, 40, 1'b1};

        // Reset with random column noise
        reset = 1'b1; clear = 1'b0; rnd_mode = 1'b1;
        repeat (3) begin
            rnd_cols = 4'($urandom);
            @(negedge clk);
        end
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_select", 32'(select), 32'hF);
        check("reset_rows", 32'(keypad_rows), 32'hF);
        check("reset_strobe", 32'(key_strobe), 32'h0);
        check("reset_value", 32'(key_value), 32'h0);
        reset = 1'b0; rnd_mode = 1'b0;
        @(negedge clk);
        check("rows_after_reset", 32'(keypad_rows), 32'hE);
        check_display("empty");

        // Table of clean presses
        for (int v = 0; v < 13; v++) begin
            exp_q.push_back(vecs[v].val);
            model_push(vecs[v].val);
            press = vecs[v].mask;
            repeat (vecs[v].hold) @(negedge clk);
            check($sformatf("strobe_seen_%0d", v), exp_q.size(), 0);
            press = '0;
            repeat (30) @(negedge clk);
            if (vecs[v].chk) check_display($sformatf("disp_%0d", v));
        end

        // Press and release bounce on key 9
        s0 = strobes;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) press = press ^ 16'h0400;
            @(negedge clk);
        end
        check("bounce_no_strobe", strobes - s0, 0);
        exp_q.push_back(4'h9);
        model_push(4'h9);
        press = 16'h0400;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) press = press ^ 16'h0400;
            @(negedge clk);
        end
        press = '0;
        repeat (30) @(negedge clk);
        check("bounce_single_strobe", strobes - s0, 1);

        // Second key pressed while first is held
        exp_q.push_back(4'h1);
        model_push(4'h1);
        press = 16'h0001;
        repeat (40) @(negedge clk);
        check("held_first_strobe", exp_q.size(), 0);
        s0 = strobes;
        press = 16'h0021;
        repeat (40) @(negedge clk);
        check("held_second_ignored", strobes - s0, 0);
        exp_q.push_back(4'h5);
        model_push(4'h5);
        press = 16'h0020;
        rel_cyc = cyc;
        repeat (60) @(negedge clk);
        check("second_after_release", exp_q.size(), 0);
        check("second_delay_ok", 32'(last_strobe_cyc - rel_cyc >= 2 * DEB), 32'h1);
        press = '0;
        repeat (30) @(negedge clk);
        check_display("after_rollover");

        // clear coinciding with a strobe
        exp_q.push_back(4'h4);
        press = 16'h0010;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (key_strobe) found = 1;
        end
        check("clear_strobe_seen", 32'(found), 32'h1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_valid = '0;
        press = '0;
        repeat (30) @(negedge clk);
        check_display("after_clear");

        // Reset while debouncing key D
        s0 = strobes;
        press = 16'h8000;
        found = 0;
        rel_cyc = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (keypad_rows == 4'b0111) rel_cyc++; else rel_cyc = 0;
            if (rel_cyc >= 6) found = 1;
        end
        check("debounce_reached", 32'(found), 32'h1);
        reset = 1'b1;
        press = '0;
        @(negedge clk);
        check("midreset_seg", 32'(seg), 32'h7F);
        check("midreset_select", 32'(select), 32'hF);
        check("midreset_rows", 32'(keypad_rows), 32'hF);
        @(negedge clk);
        reset = 1'b0;
        m_valid = '0;
        repeat (40) @(negedge clk);
        check("midreset_no_strobe", strobes - s0, 0);
        check("queue_drained", exp_q.size(), 0);
        check_display("after_midreset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
